// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: WIDTH-bit add/subtract computed one 4-bit nibble per
// clock through a single 4-bit slice and a carry register, using a
// start/busy/done handshake.
// Optional feature macro: NIBBLE_SERIAL_OVF_EN adds a signed-overflow output.
module nibble_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
`ifdef NIBBLE_SERIAL_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       sum5;
  logic [WIDTH-1:0] work_upd;

`ifdef NIBBLE_SERIAL_OVF_EN
  logic             ovf_q, ovf_d;
  logic [3:0]       low3;
`endif

  // Shared 4-bit slice: current nibble pair plus carry, and the working
  // value with the freshly computed nibble merged in.
  always_comb begin
    a_nib    = a_q[{idx_q, 2'b00} +: 4];
    b_nib    = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};
    sum5     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    work_upd = work_q;
    work_upd[{idx_q, 2'b00} +: 4] = sum5[3:0];
`ifdef NIBBLE_SERIAL_OVF_EN
    // bit 3 of this sum is the carry into the slice MSB
    low3     = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
`endif
  end

  // Controller next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    idx_d       = idx_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    a_d         = a_q;
    b_d         = b_q;
    work_d      = work_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
`ifdef NIBBLE_SERIAL_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = op_sub;
          idx_d   = '0;
          carry_d = op_sub;   // +1 of A + ~B + 1 enters at nibble 0
          work_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        work_d  = work_upd;
        carry_d = sum5[4];
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          result_d    = work_upd;
          carry_out_d = sum5[4];
`ifdef NIBBLE_SERIAL_OVF_EN
          ovf_d       = low3[3] ^ sum5[4];
`endif
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      work_q      <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      a_q         <= a_d;
      b_q         <= b_d;
      work_q      <= work_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
`ifdef NIBBLE_SERIAL_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
`ifdef NIBBLE_SERIAL_OVF_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Testbench for nibble_serial_addsub (WIDTH=16): word-level reference model
// checked every cycle, plus directed operations with hand-computed results.
module tb_nibble_serial_addsub;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             op_sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
`ifdef NIBBLE_SERIAL_OVF_EN
  logic             overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
`ifdef NIBBLE_SERIAL_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: m_left counts sampled cycles the unit stays busy.
  int               m_left = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0;
  logic             m_sub = 1'b0;
  logic [WIDTH-1:0] exp_result = '0;
  logic             exp_carry = 1'b0;
  logic             exp_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left     = 0;
      exp_result = '0;
      exp_carry  = 1'b0;
      exp_ovf    = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_a    = a;
        m_b    = b;
        m_sub  = op_sub;
        m_left = NIBBLES + 1;
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        if (m_sub) begin
          exp_result = m_a - m_b;
          exp_carry  = (m_a >= m_b);
          exp_ovf    = (m_a[WIDTH-1] != m_b[WIDTH-1]) && (exp_result[WIDTH-1] != m_a[WIDTH-1]);
        end else begin
          exp_result = m_a + m_b;
          exp_carry  = ((32'(m_a) + 32'(m_b)) >> WIDTH) != 0;
          exp_ovf    = (m_a[WIDTH-1] == m_b[WIDTH-1]) && (exp_result[WIDTH-1] != m_a[WIDTH-1]);
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_left == 1));
    chk("result", 32'(result), 32'(exp_result));
    chk("carry_out", 32'(carry_out), 32'(exp_carry));
`ifdef NIBBLE_SERIAL_OVF_EN
    chk("overflow", 32'(overflow), 32'(exp_ovf));
`endif
  end

  // Wait (bounded) for done at a negedge; n = negedges waited.
  task automatic wait_done(input int budget, output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
      if (done) break;
    end
  endtask

  task automatic run_op(input string nm, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic isub, input logic [WIDTH-1:0] er, input logic ec, input logic ev);
    int n, bc;
    @(posedge clk); #1;
    a = ia; b = ib; op_sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ia; b = ~ib; op_sub = ~isub;   // operands may change after the start edge
    wait_done(20, n, bc);
    chk({nm, ".latency"}, 32'(n), 32'(NIBBLES + 1));
    chk({nm, ".busy_cycles"}, 32'(bc), 32'(NIBBLES + 1));
    chk({nm, ".result"}, 32'(result), 32'(er));
    chk({nm, ".carry"}, 32'(carry_out), 32'(ec));
    chk({nm, ".model_result"}, 32'(exp_result), 32'(er));
    chk({nm, ".model_carry"}, 32'(exp_carry), 32'(ec));
    chk({nm, ".model_ovf"}, 32'(exp_ovf), 32'(ev));
`ifdef NIBBLE_SERIAL_OVF_EN
    chk({nm, ".overflow"}, 32'(overflow), 32'(ev));
`endif
    @(negedge clk);
    chk({nm, ".done_width"}, 32'(done), 32'd0);
  endtask

  logic [WIDTH-1:0] bb_a [3] = '{16'h1111, 16'h5000, 16'h8000};
  logic [WIDTH-1:0] bb_b [3] = '{16'h2222, 16'h0001, 16'h8000};
  logic             bb_s [3] = '{1'b0, 1'b1, 1'b0};
  logic [WIDTH-1:0] bb_r [3] = '{16'h3333, 16'h4FFF, 16'h0000};
  logic             bb_c [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    int n, bc, last_cyc;
    #2;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.result", 32'(result), 32'd0);
    chk("reset.carry", 32'(carry_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("add1", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("addwrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub1", 16'h0009, 16'h0003, 1'b1, 16'h0006, 1'b1, 1'b0);
    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Borrowing subtract with a second start pulsed during RUN.
    @(posedge clk); #1;
    a = 16'h0005; b = 16'h0007; op_sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h1111; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(20, n, bc);
    chk("ignored.latency", 32'(n), 32'(NIBBLES - 1));
    chk("ignored.result", 32'(result), 32'h0000_FFFE);
    chk("ignored.carry", 32'(carry_out), 32'd0);
    repeat (4) @(negedge clk);
    chk("ignored.idle", 32'(busy), 32'd0);
    chk("ignored.held", 32'(result), 32'h0000_FFFE);

    // Reset asserted at the 2nd RUN edge of an operation.
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h0FFF; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.result", 32'(result), 32'd0);
    chk("midrst.carry", 32'(carry_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("after_rst", 16'h0100, 16'h0001, 1'b1, 16'h00FF, 1'b1, 1'b0);

    // start held high: back-to-back operations with alternating operands.
    @(posedge clk); #1;
    a = bb_a[0]; b = bb_b[0]; op_sub = bb_s[0]; start = 1'b1;
    last_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      wait_done(30, n, bc);
      chk("b2b.done_seen", 32'(done), 32'd1);
      chk("b2b.result", 32'(result), 32'(bb_r[i]));
      chk("b2b.carry", 32'(carry_out), 32'(bb_c[i]));
      if (i > 0) chk("b2b.period", 32'(cyc - last_cyc), 32'(NIBBLES + 2));
      last_cyc = cyc;
      if (i < 2) begin
        a = bb_a[i+1]; b = bb_b[i+1]; op_sub = bb_s[i+1];
      end else begin
        start = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    chk("final.idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
